// File: rtl/fast_patch_stream.sv
// fast_patch_stream: column-strip sliding-window generator for the FAST front end.
// Pixel columns of a horizontal band arrive over AXI-stream, LANES pixels per beat,
// BEATS beats per column. Every completed column shifts into a PATCH_ROWS x PATCH_W
// window, and once the window holds PATCH_W real columns of the band, each new
// column produces one output window with its centre coordinates.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   s_axis_*          : pixel-column input stream (tkeep ignored, tlast = end of frame)
//   m_patch           : flat window, element (r,c) at [((r*PATCH_W+c)+1)*PW-1 -: PW], c=0 oldest
//   m_x, m_y          : window centre column, band top row
//   m_eol, m_eof      : last window of band / of frame
//   m_valid, m_ready  : output handshake; outputs held while stalled
//   frame_err         : one-cycle pulse after a beat whose tlast disagrees with the counters

// Per-lane column-vector slice: holds this lane's pixel for each beat of the column.
// col presents the stored slots with the current beat's slot replaced by din, so the
// final beat of a column can be shifted into the window in the same cycle it arrives.
module fps_lane #(
  parameter int PW    = 8,
  parameter int BEATS = 2,
  parameter int BW    = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we,
  input  logic [BW-1:0]             beat,
  input  logic [PW-1:0]             din,
  output logic [BEATS-1:0][PW-1:0]  col
);
  logic [BEATS-1:0][PW-1:0] slot;

  always_ff @(posedge clk) begin
    if (rst)     slot <= '0;
    else if (we) slot[beat] <= din;
  end

  always_comb begin
    col       = slot;
    col[beat] = din;
  end
endmodule

module fast_patch_stream #(
  parameter int COL_NUM     = 640,
  parameter int ROW_NUM     = 480,
  parameter int PATCH_ROWS  = 8,
  parameter int PATCH_W     = 7,
  parameter int PIXEL_WIDTH = 8,
  parameter int LANES       = 4,
  parameter int ROW_STEP    = 2,
  localparam int PW     = PIXEL_WIDTH,
  localparam int BEATS  = PATCH_ROWS / LANES,
  localparam int NBANDS = (ROW_NUM - PATCH_ROWS) / ROW_STEP + 1,
  localparam int XW     = $clog2(COL_NUM),
  localparam int YW     = $clog2(ROW_NUM)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [LANES*PW-1:0]                s_axis_tdata,
  input  logic [LANES-1:0]                   s_axis_tkeep,
  input  logic                               s_axis_tlast,
  input  logic                               s_axis_tvalid,
  output logic                               s_axis_tready,
  output logic [PATCH_ROWS*PATCH_W*PW-1:0]   m_patch,
  output logic [XW-1:0]                      m_x,
  output logic [YW-1:0]                      m_y,
  output logic                               m_eol,
  output logic                               m_eof,
  output logic                               m_valid,
  input  logic                               m_ready,
  output logic                               frame_err
);
  localparam int BW  = (BEATS  > 1) ? $clog2(BEATS)  : 1;
  localparam int NBW = (NBANDS > 1) ? $clog2(NBANDS) : 1;

  typedef struct packed {
    logic [PATCH_ROWS*PATCH_W*PW-1:0] patch;
    logic [XW-1:0]                    x;
    logic [YW-1:0]                    y;
    logic                             eol;
    logic                             eof;
  } win_out_t;

  logic unused_tkeep;
  assign unused_tkeep = ^s_axis_tkeep;

  logic [BW-1:0]  beat_cnt;
  logic [XW-1:0]  col_cnt;
  logic [NBW-1:0] band_cnt;
  logic [YW-1:0]  band_y;     // band_cnt*ROW_STEP, kept incrementally

  logic [LANES-1:0][BEATS-1:0][PW-1:0]     lane_col;
  logic [PATCH_ROWS-1:0][PW-1:0]           new_col;
  logic [PATCH_W-1:0][PATCH_ROWS-1:0][PW-1:0] win, win_nxt;
  logic [PATCH_ROWS*PATCH_W*PW-1:0]        flat;
  win_out_t out_q;

  logic acc, col_done, row_end, band_last, frame_last, emit;

  // A stalled output register blocks the input in the same cycle.
  assign s_axis_tready = !rst && !(m_valid && !m_ready);
  assign acc        = s_axis_tvalid && s_axis_tready;
  assign col_done   = beat_cnt == BW'(BEATS - 1);
  assign row_end    = col_cnt == XW'(COL_NUM - 1);
  assign band_last  = band_cnt == NBW'(NBANDS - 1);
  assign frame_last = col_done && row_end && band_last;
  // Fill gating: the first PATCH_W-1 columns of a band only prime the window, which is
  // why the window never needs clearing between bands.
  assign emit       = acc && col_done && (col_cnt >= XW'(PATCH_W - 1));

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    fps_lane #(.PW(PW), .BEATS(BEATS), .BW(BW)) u_lane (
      .clk  (clk),
      .rst  (rst),
      .we   (acc),
      .beat (beat_cnt),
      .din  (s_axis_tdata[k*PW +: PW]),
      .col  (lane_col[k])
    );
    for (genvar b = 0; b < BEATS; b++) begin : g_beat
      assign new_col[b*LANES+k] = lane_col[k][b];
    end
  end

  always_comb begin
    win_nxt = win;
    for (int c = 0; c < PATCH_W - 1; c++) win_nxt[c] = win[c+1];
    win_nxt[PATCH_W-1] = new_col;
  end

  // Reorder column-major window storage into the row-major output layout.
  always_comb begin
    flat = '0;
    for (int r = 0; r < PATCH_ROWS; r++)
      for (int c = 0; c < PATCH_W; c++)
        flat[(r*PATCH_W+c)*PW +: PW] = win_nxt[c][r];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt  <= '0;
      col_cnt   <= '0;
      band_cnt  <= '0;
      band_y    <= '0;
      win       <= '0;
      out_q     <= '0;
      m_valid   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= acc && (s_axis_tlast != frame_last);
      if (acc) begin
        if (col_done) begin
          win      <= win_nxt;
          beat_cnt <= '0;
          if (row_end) begin
            col_cnt <= '0;
            if (band_last) begin
              band_cnt <= '0;
              band_y   <= '0;
            end else begin
              band_cnt <= band_cnt + 1'b1;
              band_y   <= band_y + YW'(ROW_STEP);
            end
          end else begin
            col_cnt <= col_cnt + 1'b1;
          end
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
        end
        // Early tlast: resynchronise to frame start after this beat.
        if (s_axis_tlast && !frame_last) begin
          beat_cnt <= '0;
          col_cnt  <= '0;
          band_cnt <= '0;
          band_y   <= '0;
        end
      end
      // emit implies the register is free or being drained this cycle.
      if (emit) begin
        m_valid     <= 1'b1;
        out_q.patch <= flat;
        out_q.x     <= col_cnt - XW'(PATCH_W / 2);
        out_q.y     <= band_y;
        out_q.eol   <= row_end;
        out_q.eof   <= row_end && band_last;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  assign m_patch = out_q.patch;
  assign m_x     = out_q.x;
  assign m_y     = out_q.y;
  assign m_eol   = out_q.eol;
  assign m_eof   = out_q.eof;
endmodule

// File: tb/tb_fast_patch_stream.sv
module tb_fast_patch_stream;
  localparam int COL_NUM = 16, ROW_NUM = 12, PATCH_ROWS = 8, PATCH_W = 7;
  localparam int PIX = 8, LANES = 4, ROW_STEP = 2;
  localparam int PBITS = PATCH_ROWS * PATCH_W * PIX;

  typedef struct packed {
    logic [PBITS-1:0] patch;
    logic [3:0]       x;
    logic [3:0]       y;
    logic             eol;
    logic             eof;
  } win_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [LANES*PIX-1:0] s_axis_tdata = '0;
  logic [LANES-1:0]     s_axis_tkeep = '1;
  logic                 s_axis_tlast = 1'b0;
  logic                 s_axis_tvalid = 1'b0;
  logic                 s_axis_tready;
  logic [PBITS-1:0]     m_patch;
  logic [3:0]           m_x, m_y;
  logic                 m_eol, m_eof, m_valid, frame_err;
  logic                 m_ready = 1'b1;

  fast_patch_stream #(
    .COL_NUM(COL_NUM), .ROW_NUM(ROW_NUM), .PATCH_ROWS(PATCH_ROWS), .PATCH_W(PATCH_W),
    .PIXEL_WIDTH(PIX), .LANES(LANES), .ROW_STEP(ROW_STEP)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_patch(m_patch), .m_x(m_x), .m_y(m_y), .m_eol(m_eol), .m_eof(m_eof),
    .m_valid(m_valid), .m_ready(m_ready), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  logic [7:0] img [0:ROW_NUM-1][0:COL_NUM-1];
  win_t expq[$];
  win_t obs[$];
  int checks = 0, passes = 0, fails = 0;
  int win_seen = 0, err_cnt = 0;
  int rdy_mode = 0, stall_left = 0, stall_win = -1;
  bit rand_valid = 0;

  task automatic chk(input string tag, input logic [511:0] o, input logic [511:0] e);
    checks++;
    assert (o === e) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, o, e);
    end
  endtask

  // Expected window straight from the image: newest column col of band `band`.
  function automatic win_t exp_win(input int band, input int col);
    win_t w;
    w.patch = '0;
    for (int r = 0; r < PATCH_ROWS; r++)
      for (int c = 0; c < PATCH_W; c++)
        w.patch[(r*PATCH_W+c)*PIX +: PIX] = img[band*ROW_STEP+r][col-PATCH_W+1+c];
    w.x   = 4'(col - PATCH_W/2);
    w.y   = 4'(band * ROW_STEP);
    w.eol = (col == COL_NUM-1);
    w.eof = (col == COL_NUM-1) && (band == 2);
    return w;
  endfunction

  task automatic fill_ramp();
    for (int r = 0; r < ROW_NUM; r++)
      for (int c = 0; c < COL_NUM; c++) img[r][c] = 8'(r*16 + c);
  endtask

  task automatic fill_rand();
    for (int r = 0; r < ROW_NUM; r++)
      for (int c = 0; c < COL_NUM; c++) img[r][c] = 8'($urandom);
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat is accepted.
  task automatic send_beat(input int i, input bit last);
    int band, rem, col, bc;
    logic [LANES*PIX-1:0] d;
    bit acc;
    band = i / 32; rem = i % 32; col = rem / 2; bc = rem % 2;
    for (int k = 0; k < LANES; k++) d[k*PIX +: PIX] = img[band*ROW_STEP + bc*LANES + k][col];
    if (rand_valid)
      while ($urandom_range(1) == 0) begin @(posedge clk); #1; end
    s_axis_tvalid = 1'b1; s_axis_tdata = d; s_axis_tlast = last;
    acc = 0;
    for (int g = 0; g < 200 && !acc; g++) begin
      @(negedge clk); acc = s_axis_tready;
      @(posedge clk); #1;
    end
    chk("beat_accept", 512'(acc), 512'(1));
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    if (bc == 1 && col >= PATCH_W-1) expq.push_back(exp_win(band, col));
  endtask

  task automatic send_frame(input int n, input int tlast_at);
    for (int i = 0; i < n; i++) send_beat(i, i == tlast_at);
  endtask

  task automatic drain();
    for (int g = 0; g < 2000 && (expq.size() != 0 || m_valid); g++) begin @(posedge clk); #1; end
    chk("drain_empty", 512'(expq.size()), 512'(0));
  endtask

  // Downstream ready generator, with a targeted 5-cycle stall on window stall_win.
  always begin
    @(posedge clk); #1;
    if (rdy_mode == 1) m_ready = ($urandom_range(9) < 3);
    else               m_ready = 1'b1;
    if (stall_left > 0 && m_valid && win_seen == stall_win) begin
      m_ready = 1'b0;
      stall_left--;
    end
  end

  // Output monitor / scoreboard.
  always @(negedge clk) begin
    win_t cur;
    if (!rst) begin
      if (frame_err) err_cnt++;
      if (m_valid) begin
        cur = {m_patch, m_x, m_y, m_eol, m_eof};
        if (expq.size() == 0) begin
          chk("spurious_window", 512'(m_valid), 512'(0));
        end else if (!m_ready) begin
          chk("stall_hold", 512'(cur), 512'(expq[0]));
          chk("stall_tready", 512'(s_axis_tready), 512'(0));
        end else begin
          chk("window", 512'(cur), 512'(expq.pop_front()));
          obs.push_back(cur);
          win_seen++;
        end
      end
    end
  end

  initial begin
    win_t w;
    logic [11:0] yseq;
    int nb;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tready", 512'(s_axis_tready), 512'(0));
    chk("rst_valid",  512'(m_valid), 512'(0));
    chk("rst_patch",  512'(m_patch), 512'(0));
    chk("rst_x",      512'(m_x), 512'(0));
    chk("rst_y",      512'(m_y), 512'(0));
    chk("rst_eol",    512'(m_eol), 512'(0));
    chk("rst_eof",    512'(m_eof), 512'(0));
    chk("rst_ferr",   512'(frame_err), 512'(0));
    @(posedge clk); #1; rst = 1'b0;

    // Ramp frame
    fill_ramp(); obs.delete(); err_cnt = 0;
    send_frame(96, 95); drain();
    chk("ramp_count", 512'(obs.size()), 512'(30));
    w = obs[0];
    chk("ramp_first_x", 512'(w.x), 512'(3));
    chk("ramp_first_y", 512'(w.y), 512'(0));
    chk("ramp_e00", 512'(w.patch[7:0]), 512'(8'h00));
    chk("ramp_e76", 512'(w.patch[(7*PATCH_W+6)*PIX +: PIX]), 512'(8'h76));
    w = obs[obs.size()-1];
    chk("ramp_last", 512'({w.x, w.y, w.eol, w.eof}), 512'({4'd12, 4'd4, 1'b1, 1'b1}));
    chk("ramp_no_ferr", 512'(err_cnt), 512'(0));

    // Stall on window 4
    obs.delete(); win_seen = 0; stall_win = 4; stall_left = 5;
    send_frame(96, 95); drain();
    chk("stall_count", 512'(obs.size()), 512'(30));
    chk("stall_done", 512'(stall_left), 512'(0));
    stall_win = -1;

    // Early tlast on beat 20
    err_cnt = 0;
    send_frame(21, 20);
    @(negedge clk);
    chk("early_ferr_pulse", 512'(frame_err), 512'(1));
    @(posedge clk); #1;
    drain(); obs.delete();
    send_frame(96, 95); drain();
    chk("early_next_count", 512'(obs.size()), 512'(30));
    w = obs[0];
    chk("early_next_first", 512'(w), 512'(exp_win(0, 6)));
    chk("early_ferr_once", 512'(err_cnt), 512'(1));

    // Missing tlast on beat 95
    err_cnt = 0;
    send_frame(96, -1);
    @(negedge clk);
    chk("miss_ferr_pulse", 512'(frame_err), 512'(1));
    @(posedge clk); #1;
    drain(); obs.delete();
    send_frame(96, 95); drain();
    chk("miss_next_count", 512'(obs.size()), 512'(30));
    chk("miss_ferr_once", 512'(err_cnt), 512'(1));

    // Reset mid-frame at beat 40
    send_frame(40, -1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_valid", 512'(m_valid), 512'(0));
    chk("midrst_tready", 512'(s_axis_tready), 512'(0));
    expq.delete();
    @(posedge clk); #1; rst = 1'b0;
    obs.delete();
    send_frame(96, 95); drain();
    chk("midrst_count", 512'(obs.size()), 512'(30));
    yseq = '0; nb = 0;
    foreach (obs[i]) if (obs[i].x == 4'd3) begin yseq = {yseq[7:0], obs[i].y}; nb++; end
    chk("midrst_bands", 512'(nb), 512'(3));
    chk("midrst_yseq", 512'(yseq), 512'(12'h024));

    // Random valid / ready on random image
    fill_rand(); obs.delete(); rand_valid = 1; rdy_mode = 1;
    send_frame(96, 95); drain();
    chk("rand_count", 512'(obs.size()), 512'(30));
    rand_valid = 0; rdy_mode = 0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/fast_patch_stream.md
# fast_patch_stream

Parametrised column-strip patch generator for the FAST front end. It accepts pixel columns of a horizontal image band over AXI-stream, LANES pixels per beat, and assembles them into a PATCH_ROWS x PATCH_W sliding window. Each completed window is emitted as a flat bus with centre coordinates. It generalises the fixed 8x7 / 4-lane window buffer in lane count, patch geometry and band step, and adds output backpressure, end-of-line and end-of-frame markers, and framing-error detection.

## Interface
- COL_NUM, 640, image width in pixels
- ROW_NUM, 480, image height in pixels
- PATCH_ROWS, 8, band height: rows per column vector; must be a multiple of LANES
- PATCH_W, 7, window width in columns; 3..COL_NUM
- PIXEL_WIDTH, 8, bits per pixel
- LANES, 4, pixels per input beat; s_axis_tdata width = LANES*PIXEL_WIDTH
- ROW_STEP, 2, row advance between consecutive bands
- Derived values:
  - BEATS = PATCH_ROWS/LANES
  - NBANDS = (ROW_NUM-PATCH_ROWS)/ROW_STEP+1
  - XW = clogb2(COL_NUM), YW = clogb2(ROW_NUM)
- clk  in  1  single clock; everything is sampled on its rising edge
- rst  in  1  synchronous reset, active-high
- s_axis_tdata  in  LANES*PIXEL_WIDTH  lane k (bits [(k+1)*PW-1 -: PW]) = row band_top+beat*LANES+k
- s_axis_tkeep  in  LANES  ignored; all lanes are treated as valid
- s_axis_tlast  in  1  last beat of the frame
- s_axis_tvalid  in  1  input beat valid
- s_axis_tready  out  1  input accept
- m_patch  out  PATCH_ROWS*PATCH_W*PIXEL_WIDTH  element (r,c) at bits [((r*PATCH_W+c)+1)*PW-1 -: PW]; c=0 is the oldest column
- m_x  out  XW  window centre column = newest column − PATCH_W/2
- m_y  out  YW  band top row
- m_eol  out  1  this window is the last one of its band
- m_eof  out  1  this window is the last one of the frame
- m_valid  out  1  window valid
- m_ready  in  1  downstream accept
- frame_err  out  1  one-cycle pulse on a tlast mismatch

## Operation
- Counters:
  - beat_cnt: 0..BEATS-1
  - col_cnt: 0..COL_NUM-1
  - band_cnt: 0..NBANDS-1
- An accepted beat (s_axis_tvalid && s_axis_tready) writes LANES pixels into column-vector slice beat_cnt, then increments beat_cnt.
- On the final beat of a column (beat_cnt == BEATS-1):
  - the completed column vector shifts into the window; column c takes column c+1, and column PATCH_W-1 takes the new vector;
  - col_cnt increments.
- A window is produced when col_cnt ≥ PATCH_W-1 at that final beat. Columns 0..PATCH_W-2 of each band only fill the window; no output is produced for them.
- Windows per band = COL_NUM−PATCH_W+1. Band top row = band_cnt*ROW_STEP.
- Window markers:
  - m_eol = 1 when col_cnt == COL_NUM-1.
  - m_eof = m_eol && band_cnt == NBANDS-1.
- At col_cnt wrap, band_cnt increments; it wraps to 0 after the last band, and the next frame starts.
- The window contents are not cleared between bands. The fill gating alone guarantees that no stale column is ever emitted.
- Framing:
  - tlast is expected only on the last beat of the frame.
  - Early tlast: frame_err pulses, and all counters reset to 0 after that beat. No m_eof is issued.
  - tlast missing on the expected beat: frame_err pulses, and the counters wrap normally.
- Output register: m_patch, m_x, m_y, m_eol and m_eof are held stable while m_valid && !m_ready.

## Timing
- Reset: the values below hold in the cycle after rst is sampled high and stay there while rst is high. The first beat can be accepted in the cycle after rst is released.
  - s_axis_tready = 0
  - m_valid = 0, m_patch = 0, m_x = 0, m_y = 0
  - m_eol = 0, m_eof = 0, frame_err = 0
  - all counters = 0
- s_axis_tready = !rst && !(m_valid && !m_ready). It is combinational from the output register state, so a downstream stall back-pressures the input in the same cycle.
- Latency: m_valid rises in the cycle after the final column beat is accepted.
- m_valid falls after a cycle with m_ready = 1, unless a new window is loaded in that same cycle. Simultaneous accept and reload gives back-to-back windows.
- Throughput: one window per BEATS accepted beats, with no bubbles when m_ready stays high.
- frame_err is registered: it is high in the cycle after the offending beat.
- rst asserted mid-frame: any pending window is discarded and m_valid = 0 in the next cycle. The next accepted beat after release is treated as frame beat 0.

## Test plan
Bench parameters: COL_NUM=16, ROW_NUM=12, PATCH_ROWS=8, PATCH_W=7, LANES=4, ROW_STEP=2. This gives NBANDS=3, BEATS=2 and 10 windows per band.
- Ramp frame (pixel = row*16+col), m_ready=1 throughout:
  - 30 windows total;
  - first window has m_x=3, m_y=0, element (0,0)=0x00, element (7,6)=0x76;
  - last window has m_x=12, m_y=4, m_eol=1, m_eof=1;
  - frame_err never fires.
- m_ready held low for 5 cycles on window 4:
  - m_patch/m_x stay stable;
  - s_axis_tready=0 during the stall;
  - no window is lost or duplicated, and the frame still yields 30 windows.
- Early tlast on beat 20:
  - frame_err pulses exactly once;
  - the next frame's first window is m_x=3, m_y=0 with correct ramp contents.
- Missing tlast on beat 95:
  - frame_err pulses;
  - the following frame produces 30 correct windows.
- rst pulse at beat 40, then a full frame: 30 windows with m_y sequence 0,2,4.
- Random s_axis_tvalid (50%) and m_ready (30%): the output sequence matches the reference model bit-exactly.
